// File: rtl/wr_ctrl_pkg.sv
// Shared types for the ADC-to-FIFO write controller: one-hot FSM state and frame counter width.
package wr_ctrl_pkg;

    typedef enum logic [4:0] {
        FIFO_RST = 5'b00001,
        SETTLE   = 5'b00010,
        IDLE     = 5'b00100,
        CAPTURE  = 5'b01000,
        DRAIN    = 5'b10000
    } wr_state_t;

    localparam int FRAME_CNT_W = 16;

endpackage

// File: rtl/write_controller_if.sv
// FIFO write-side bundle between the write controller (master) and the ADC/FIFO side (slave).
// Handshake: a sample is accepted by the FIFO in exactly the cycle where wr_en=1; wr_en is only
// ever raised when adc_valid=1 and full=0, so there is no backpressure beyond the full flag.
interface write_controller_if;
    logic adc_valid;
    logic full;
    logic empty;
    logic fifo_rst;
    logic wr_en;

    modport master (input adc_valid, full, empty, output fifo_rst, wr_en);
    modport slave  (output adc_valid, full, empty, input fifo_rst, wr_en);
endinterface

// File: rtl/wr_ctrl_timer.sv
// Loadable down-counter. o_done pulses in the cycle the count reaches 1; o_busy is high while nonzero.
module wr_ctrl_timer #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         i_load,
    input  logic [W-1:0] i_value,
    output logic         o_busy,
    output logic         o_done
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_value;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    assign o_busy = (r_cnt != '0);
    assign o_done = (r_cnt == W'(1));

endmodule

// File: rtl/write_controller.sv
// Write-side controller for the ADC sample FIFO: reset/settle the FIFO, write one frame, wait for drain.
// Optional external trigger arming is enabled with the WRITE_CTRL_EXT_TRIGGER_EN macro.
module write_controller
    import wr_ctrl_pkg::*;
#(
    parameter int RST_CYCLES    = 8,
    parameter int SETTLE_CYCLES = 32,
    parameter int FRAME_LEN     = 4096,
    parameter int CNT_W         = $clog2(FRAME_LEN + 1)
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   enable,
`ifdef WRITE_CTRL_EXT_TRIGGER_EN
    input  logic                   trig,
`endif
    write_controller_if.master     bus,
    output logic                   capturing,
    output logic [FRAME_CNT_W-1:0] frame_cnt,
    output logic                   overflow,
    output wr_state_t              o_dbg_state
);

    localparam int TMR_MAX = (RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    wr_state_t              r_state;
    wr_state_t              w_state_nxt;
    logic                   r_fifo_rst;
    logic [CNT_W-1:0]       r_smp_cnt;
    logic [FRAME_CNT_W-1:0] r_frame_cnt;
    logic                   r_overflow;
    logic                   w_wr_en;
    logic                   w_start;
    logic                   w_frame_done;
    logic                   w_arm;
    logic                   w_tmr_load;
    logic [TMR_W-1:0]       w_tmr_value;
    logic                   w_tmr_busy;
    logic                   w_tmr_done;

`ifdef WRITE_CTRL_EXT_TRIGGER_EN
    logic r_trig_d;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_trig_d <= 1'b0;
        else       r_trig_d <= trig;
    end

    assign w_arm = trig & ~r_trig_d;
`else
    assign w_arm = 1'b1;
`endif

    // The timer reloads on the first cycle of each timed state (count is 0 there), so a load of
    // N-1 keeps the FSM in that state for exactly N cycles. RST_CYCLES and SETTLE_CYCLES must be >= 2.
    assign w_tmr_load  = ((r_state == FIFO_RST) || (r_state == SETTLE)) && !w_tmr_busy;
    assign w_tmr_value = (r_state == FIFO_RST) ? TMR_W'(RST_CYCLES - 1) : TMR_W'(SETTLE_CYCLES - 1);

    wr_ctrl_timer #(.W(TMR_W)) u_timer (
        .clk     (clk),
        .rstn    (rstn),
        .i_load  (w_tmr_load),
        .i_value (w_tmr_value),
        .o_busy  (w_tmr_busy),
        .o_done  (w_tmr_done)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_state <= FIFO_RST;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_wr_en      = 1'b0;
        w_start      = 1'b0;
        w_frame_done = 1'b0;
        case (r_state)
            FIFO_RST: if (w_tmr_done) w_state_nxt = SETTLE;
            SETTLE:   if (w_tmr_done) w_state_nxt = IDLE;
            IDLE: begin
                if (enable && bus.empty && w_arm) begin
                    w_state_nxt = CAPTURE;
                    w_start     = 1'b1;
                end
            end
            CAPTURE: begin
                w_wr_en = bus.adc_valid & ~bus.full;
                // full and the last write landing together still end the frame only once
                if (bus.full || (w_wr_en && (r_smp_cnt == CNT_W'(FRAME_LEN - 1)))) begin
                    w_state_nxt  = DRAIN;
                    w_frame_done = 1'b1;
                end
            end
            DRAIN:    if (bus.empty) w_state_nxt = IDLE;
            default:  w_state_nxt = FIFO_RST;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_fifo_rst  <= 1'b1;
            r_smp_cnt   <= '0;
            r_frame_cnt <= '0;
            r_overflow  <= 1'b0;
        end else begin
            r_fifo_rst <= (w_state_nxt == FIFO_RST);
            if (w_start)      r_smp_cnt <= '0;
            else if (w_wr_en) r_smp_cnt <= r_smp_cnt + CNT_W'(1);
            if (w_frame_done) r_frame_cnt <= r_frame_cnt + FRAME_CNT_W'(1);
            if ((r_state == CAPTURE) && bus.adc_valid && bus.full) r_overflow <= 1'b1;
        end
    end

    assign bus.fifo_rst = r_fifo_rst;
    assign bus.wr_en    = w_wr_en;
    assign capturing    = (r_state == CAPTURE);
    assign frame_cnt    = r_frame_cnt;
    assign overflow     = r_overflow;
    assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_write_controller.sv
// Self-checking bench for write_controller: directed phases plus random traffic against a
// cycle-level behavioural model of the startup/frame/drain sequence.
module tb_write_controller;
    import wr_ctrl_pkg::*;

    localparam int RST_C = 8;
    localparam int SET_C = 32;
    localparam int FLEN  = 16;

    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic        enable = 1'b0;
    logic        adc_valid = 1'b0;
    logic        full = 1'b0;
    logic        empty = 1'b0;
    logic        trig = 1'b0;
    logic        capturing;
    logic [15:0] frame_cnt;
    logic        overflow;
    wr_state_t   dbg_state;

    write_controller_if bus ();
    assign bus.adc_valid = adc_valid;
    assign bus.full      = full;
    assign bus.empty     = empty;

    write_controller #(
        .RST_CYCLES    (RST_C),
        .SETTLE_CYCLES (SET_C),
        .FRAME_LEN     (FLEN)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .enable      (enable),
`ifdef WRITE_CTRL_EXT_TRIGGER_EN
        .trig        (trig),
`endif
        .bus         (bus),
        .capturing   (capturing),
        .frame_cnt   (frame_cnt),
        .overflow    (overflow),
        .o_dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    // behavioural model
    int m_since;
    bit m_in_frame, m_draining, m_ovf, m_trig_prev;
    int m_writes, m_frames;

    int vectors = 0;
    int miscompares = 0;
    int cyc, n_fifo_hi, n_wr, n_cap, n_bad, first_wr, cap_idx, guard;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic void timeout(string name);
        vectors++;
        miscompares++;
        $display("FAIL timeout_%s: cycle budget expired (t=%0t)", name, $time);
    endfunction

    function automatic void m_reset();
        m_since = 0; m_in_frame = 0; m_draining = 0; m_ovf = 0;
        m_trig_prev = 0; m_writes = 0; m_frames = 0;
    endfunction

    function automatic wr_state_t m_state();
        if (!rstn || m_since < RST_C)  return FIFO_RST;
        if (m_since < RST_C + SET_C)   return SETTLE;
        if (m_in_frame)                return CAPTURE;
        if (m_draining)                return DRAIN;
        return IDLE;
    endfunction

    function automatic void model_update();
        bit we, arm, startup;
        if (!rstn) return;
`ifdef WRITE_CTRL_EXT_TRIGGER_EN
        arm = trig && !m_trig_prev;
`else
        arm = 1'b1;
`endif
        startup = (m_since < RST_C + SET_C);
        if (m_in_frame) begin
            we = adc_valid && !full;
            if (adc_valid && full) m_ovf = 1;
            if (we) m_writes++;
            if (full || (we && m_writes == FLEN)) begin
                m_in_frame = 0;
                m_draining = 1;
                m_frames = (m_frames + 1) % 65536;
            end
        end else if (m_draining) begin
            if (empty) m_draining = 0;
        end else if (!startup && enable && empty && arm) begin
            m_in_frame = 1;
            m_writes = 0;
        end
        if (m_since < 100000) m_since++;
        m_trig_prev = trig;
    endfunction

    function automatic void check_all();
        chk("fifo_rst",  bus.fifo_rst, (!rstn || m_since < RST_C));
        chk("wr_en",     bus.wr_en, m_in_frame && adc_valid && !full);
        chk("capturing", capturing, m_in_frame);
        chk("frame_cnt", frame_cnt, m_frames);
        chk("overflow",  overflow, m_ovf);
        chk("state",     dbg_state, m_state());
    endfunction

    function automatic void clear_counts();
        n_fifo_hi = 0; n_wr = 0; n_cap = 0; n_bad = 0; first_wr = -1;
    endfunction

    task automatic tick();
        #1;
        check_all();
        if (bus.fifo_rst) n_fifo_hi++;
        if (bus.wr_en) begin
            n_wr++;
            if (first_wr < 0) first_wr = cyc;
            if (!adc_valid) n_bad++;
        end
        if (capturing) n_cap++;
        @(posedge clk);
        model_update();
        @(negedge clk);
`ifdef WRITE_CTRL_EXT_TRIGGER_EN
        trig = ~trig;
`endif
        cyc++;
    endtask

    // asynchronous reset away from any clock edge, released on a falling edge
    task automatic do_reset();
        #2 rstn = 1'b0;
        #1 m_reset();
        chk("rst_fifo_rst",  bus.fifo_rst, 1);
        chk("rst_wr_en",     bus.wr_en, 0);
        chk("rst_capturing", capturing, 0);
        chk("rst_frame_cnt", frame_cnt, 0);
        chk("rst_overflow",  overflow, 0);
        chk("rst_state",     dbg_state, FIFO_RST);
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        cyc = 0;
        clear_counts();
    endtask

    initial begin
        m_reset();
        do_reset();

        // startup timing and a full uninterrupted frame
        enable = 1; adc_valid = 1; empty = 1; full = 0;
        guard = 0;
        while (m_frames < 1 && guard < 300) begin tick(); guard++; end
        if (guard >= 300) timeout("first_frame");
        chk("pulse_len", n_fifo_hi, 8);
`ifndef WRITE_CTRL_EXT_TRIGGER_EN
        chk("first_wr_cycle", first_wr, 41);
`endif
        chk("frame1_writes", n_wr, 16);
        chk("frame1_cnt", frame_cnt, 1);
        chk("frame1_drain", dbg_state, DRAIN);

        // alternating adc_valid: 16 writes over 31 capture cycles
        clear_counts(); cap_idx = 0; guard = 0;
        while (m_frames < 2 && guard < 300) begin
            if (m_in_frame) begin adc_valid = (cap_idx % 2 == 0); cap_idx++; end
            else begin adc_valid = 1; cap_idx = 0; end
            tick(); guard++;
        end
        if (guard >= 300) timeout("toggle_frame");
        chk("toggle_writes", n_wr, 16);
        chk("toggle_cycles", n_cap, 31);
        chk("toggle_no_bad_wr", n_bad, 0);

        // full after 10 writes terminates the frame and flags the drop
        clear_counts(); adc_valid = 1; guard = 0;
        while (m_frames < 3 && guard < 300) begin
            full = m_in_frame && (m_writes == 10);
            tick(); guard++;
        end
        if (guard >= 300) timeout("full_frame");
        full = 0;
        chk("full_writes", n_wr, 10);
        chk("full_overflow", overflow, 1);
        chk("full_state", dbg_state, DRAIN);
        chk("full_cnt", frame_cnt, 3);

        // long drain, then a single-cycle empty pulse
        clear_counts(); empty = 0;
        repeat (100) tick();
        chk("drain_no_wr", n_wr, 0);
        chk("drain_hold_state", dbg_state, DRAIN);
        empty = 1; tick();
        empty = 0; tick();
        chk("drain_to_idle", dbg_state, IDLE);
        clear_counts(); empty = 1; guard = 0;
        while (m_frames < 4 && guard < 300) begin tick(); guard++; end
        if (guard >= 300) timeout("post_drain_frame");
        chk("post_drain_writes", n_wr, 16);

        // random traffic
        for (int i = 0; i < 1500; i++) begin
            enable    = ($urandom_range(0, 9) != 0);
            adc_valid = ($urandom_range(0, 3) != 0);
            empty     = ($urandom_range(0, 2) == 0);
            full      = ($urandom_range(0, 24) == 0);
`ifdef WRITE_CTRL_EXT_TRIGGER_EN
            trig      = $urandom_range(0, 1);
`endif
            tick();
        end

        // reset in the middle of a frame
        enable = 1; adc_valid = 1; empty = 1; full = 0; guard = 0;
        while (!(m_in_frame && m_writes >= 5) && guard < 300) begin tick(); guard++; end
        if (guard >= 300) timeout("mid_capture");
        do_reset();
        repeat (45) tick();
        chk("repulse_len", n_fifo_hi, 8);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
